// File: rtl/chain_seq.sv
// Sequencer for the int8 dual-weight MAC chain: issues tile reads, tracks chain latency,
// accumulates per-tile results and hands out finished pairs. CHAIN_SEQ_SAT_EN enables saturation.
module chain_seq #(
    parameter int unsigned NUM_TILES     = 4,
    parameter int unsigned NUM_PAIRS     = 8,
    parameter int unsigned CHAIN_LATENCY = 11,
    parameter int unsigned IN_WIDTH      = 20,
    parameter int unsigned ACC_WIDTH     = 24,
    localparam int unsigned TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
    localparam int unsigned PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [TILE_W-1:0]           tile_addr,
    output logic [PAIR_W-1:0]           pair_addr,
    input  logic signed [IN_WIDTH-1:0]  chain_j,
    input  logic signed [IN_WIDTH-1:0]  chain_k,
    output logic signed [ACC_WIDTH-1:0] out_j,
    output logic signed [ACC_WIDTH-1:0] out_k,
    output logic                        out_valid,
    input  logic                        out_ready
);

    // One stage for the memory read, then the chain's own latency.
    localparam int unsigned DEPTH = 1 + CHAIN_LATENCY;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOutput} state_e;

    state_e                 state_q, state_d;
    logic [TILE_W-1:0]      tile_q, tile_d;
    logic [PAIR_W-1:0]      pair_q, pair_d;
    logic                   done_q, done_d;
    logic [DEPTH-1:0]       sr_valid_q, sr_first_q, sr_last_q;
    logic signed [ACC_WIDTH-1:0] acc_j_q, acc_k_q;
    logic                   issue, issue_first, issue_last, res_valid;

    function automatic logic signed [ACC_WIDTH-1:0] acc_add(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic                        first,
        input logic signed [IN_WIDTH-1:0]  x
    );
`ifdef CHAIN_SEQ_SAT_EN
        logic signed [ACC_WIDTH:0] a, b, s;
        a = first ? '0 : (ACC_WIDTH + 1)'(acc);
        b = (ACC_WIDTH + 1)'(x);
        s = a + b;
        // Top two bits disagree only when the true sum left the ACC_WIDTH range.
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
        end
        return s[ACC_WIDTH-1:0];
`else
        return (first ? '0 : acc) + ACC_WIDTH'(x);
`endif
    endfunction

    assign issue       = (state_q == StIssue);
    assign issue_first = issue && (tile_q == '0);
    assign issue_last  = issue && (tile_q == TILE_W'(NUM_TILES - 1));
    assign res_valid   = sr_valid_q[DEPTH-1];

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        pair_d  = pair_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is not a new layer.
                if (start && !done_q) begin
                    state_d = StIssue;
                    tile_d  = '0;
                    pair_d  = '0;
                end
            end
            StIssue: begin
                if (issue_last) begin
                    state_d = StWait;
                    tile_d  = '0;
                end else begin
                    tile_d = tile_q + 1'b1;
                end
            end
            StWait: begin
                if (res_valid && sr_last_q[DEPTH-1]) state_d = StOutput;
            end
            StOutput: begin
                if (out_ready) begin
                    if (pair_q == PAIR_W'(NUM_PAIRS - 1)) begin
                        state_d = StIdle;
                        pair_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StIssue;
                        pair_d  = pair_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            tile_q     <= '0;
            pair_q     <= '0;
            done_q     <= 1'b0;
            sr_valid_q <= '0;
            sr_first_q <= '0;
            sr_last_q  <= '0;
            acc_j_q    <= '0;
            acc_k_q    <= '0;
        end else begin
            state_q    <= state_d;
            tile_q     <= tile_d;
            pair_q     <= pair_d;
            done_q     <= done_d;
            sr_valid_q <= {sr_valid_q[DEPTH-2:0], issue};
            sr_first_q <= {sr_first_q[DEPTH-2:0], issue_first};
            sr_last_q  <= {sr_last_q[DEPTH-2:0], issue_last};
            if (res_valid) begin
                acc_j_q <= acc_add(acc_j_q, sr_first_q[DEPTH-1], chain_j);
                acc_k_q <= acc_add(acc_k_q, sr_first_q[DEPTH-1], chain_k);
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign rd_en     = issue;
    assign tile_addr = tile_q;
    assign pair_addr = pair_q;
    assign out_valid = (state_q == StOutput);
    assign out_j     = acc_j_q;
    assign out_k     = acc_k_q;

endmodule

// File: tb/tb_chain_seq.sv
// Directed bench for chain_seq with a behavioural chain model; chain inputs are 24 bits wide
// so single partials of +/-2^22 can be driven.
module tb_chain_seq;

    localparam int NT  = 4;
    localparam int NP  = 8;
    localparam int CL  = 11;
    localparam int IW  = 24;
    localparam int AW  = 24;
    localparam int LAT = NT + CL + 2;
`ifdef CHAIN_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset, start, out_ready;
    logic                 busy, done, rd_en, out_valid;
    logic [1:0]           tile_addr;
    logic [2:0]           pair_addr;
    logic signed [IW-1:0] chain_j, chain_k;
    logic signed [AW-1:0] out_j, out_k;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int done_cnt = 0;

    chain_seq #(
        .NUM_TILES(NT), .NUM_PAIRS(NP), .CHAIN_LATENCY(CL), .IN_WIDTH(IW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
        .tile_addr(tile_addr), .pair_addr(pair_addr), .chain_j(chain_j), .chain_k(chain_k),
        .out_j(out_j), .out_k(out_k), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Chain model: read strobe, one memory cycle, then CL cycles of chain latency.
    logic m_v [0:CL];
    int   m_t [0:CL];
    int   m_p [0:CL];
    always @(posedge clk) begin
        m_v[0] <= rd_en;
        m_t[0] <= int'(tile_addr);
        m_p[0] <= int'(pair_addr);
        for (int i = 1; i <= CL; i++) begin
            m_v[i] <= m_v[i-1];
            m_t[i] <= m_t[i-1];
            m_p[i] <= m_p[i-1];
        end
    end

    always_comb begin
        chain_j = IW'(12345);
        chain_k = -IW'(777);
        if (m_v[CL] === 1'b1) begin
            if (mode == 0) begin
                chain_j = IW'(100 * (m_t[CL] + 1) + m_p[CL]);
                chain_k = IW'(-(m_t[CL] + 1));
            end else begin
                chain_j = IW'(1 << 22);
                chain_k = IW'(-(1 << 22));
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_j(input int p);
        if (mode == 0) return 1000 + 4 * p;
        return SAT ? 8388607 : 0;
    endfunction

    function automatic int exp_k();
        if (mode == 0) return -10;
        return SAT ? -8388608 : 0;
    endfunction

    // Full layer; hold = cycles out_ready stays low on pair 0, poke = stray start pulses.
    task automatic run_layer(input int hold, input bit poke);
        int cnt;
        bit found;
        int d0;
        d0 = done_cnt;
        out_ready = (hold == 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            cnt = 0;
            found = 1'b0;
            while (!found && cnt < 100) begin
                @(negedge clk);
                cnt++;
                if (cnt == 1) begin
                    start = 1'b0;
                    check_eq("out_valid_low_after_hs", int'(out_valid), 0);
                    check_eq("busy", int'(busy), 1);
                end
                if (cnt >= 1 && cnt <= NT) begin
                    check_eq("rd_en_issue", int'(rd_en), 1);
                    check_eq("tile_addr", int'(tile_addr), cnt - 1);
                    check_eq("pair_addr_issue", int'(pair_addr), p);
                end
                if (cnt == NT + 1) begin
                    check_eq("rd_en_wait", int'(rd_en), 0);
                    check_eq("tile_addr_idle", int'(tile_addr), 0);
                end
                if (poke && cnt == 8) start = 1'b1;
                if (poke && cnt == 9) start = 1'b0;
                if (out_valid === 1'b1) found = 1'b1;
            end
            check_eq("valid_timeout", int'(found), 1);
            if (!found) return;
            check_eq("valid_latency", cnt, LAT);
            check_eq("pair_addr_out", int'(pair_addr), p);
            check_eq("out_j", int'(out_j), exp_j(p));
            check_eq("out_k", int'(out_k), exp_k());
            if (poke) start = 1'b1;
            if (p == 0 && hold > 0) begin
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    check_eq("hold_valid", int'(out_valid), 1);
                    check_eq("hold_out_j", int'(out_j), exp_j(0));
                    check_eq("hold_out_k", int'(out_k), exp_k());
                    check_eq("hold_rd_en", int'(rd_en), 0);
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        check_eq("done_pulse", int'(done), 1);
        check_eq("busy_fall", int'(busy), 0);
        check_eq("valid_after_last", int'(out_valid), 0);
        @(negedge clk);
        start = 1'b0;
        check_eq("done_clear", int'(done), 0);
        check_eq("busy_idle", int'(busy), 0);
        check_eq("rd_en_idle", int'(rd_en), 0);
        check_eq("done_count", done_cnt - d0, 1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_rd_en"}, int'(rd_en), 0);
        check_eq({tag, "_valid"}, int'(out_valid), 0);
        check_eq({tag, "_tile"}, int'(tile_addr), 0);
        check_eq({tag, "_pair"}, int'(pair_addr), 0);
        check_eq({tag, "_out_j"}, int'(out_j), 0);
        check_eq({tag, "_out_k"}, int'(out_k), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        mode = 0;
        run_layer(5, 1'b0);
        run_layer(0, 1'b1);
        mode = 1;
        run_layer(0, 1'b0);

        // Abort a pair mid-issue, then confirm no residue in the next layer.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("abort_tile", int'(tile_addr), 2);
        reset = 1'b1;
        @(negedge clk);
        check_zero("abort");
        reset = 1'b0;
        run_layer(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chain_seq.md
# chain_seq

Sequencer for the int8 dual-weight MAC chain and its pipelined adder tree. A layer is split into input tiles, and each tile is as wide as the chain. For each output neuron pair (j, k), the block issues tile reads to the input and weight memories and tracks the chain's fixed pipeline latency. It accumulates the per-tile chain outputs into full-width sums and presents each finished pair on a valid/ready output port. It sits between the layer control and the chain and owns all addressing and timing.

## Interface
- NUM_TILES, 4, number of input tiles per neuron pair (≥1)
- NUM_PAIRS, 8, number of (j, k) output pairs per layer (≥1)
- CHAIN_LATENCY, 11, cycles from tile data at chain inputs to the matching value on chain_j/chain_k (≥1)
- IN_WIDTH, 20, signed width of chain_j/chain_k
- ACC_WIDTH, 24, signed accumulator/output width (≥ IN_WIDTH)

Ports (all sampled/driven on the rising edge of clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pair is accepted
- rd_en  out  1  memory read strobe; memory data reaches the chain inputs 1 cycle later
- tile_addr  out  $clog2(NUM_TILES) (min 1)  tile index for the inputs and weights memories
- pair_addr  out  $clog2(NUM_PAIRS) (min 1)  neuron-pair index selecting the weights_j/weights_k rows
- chain_j, chain_k  in  IN_WIDTH signed  chain outputs
- out_j, out_k  out  ACC_WIDTH signed  accumulated pair result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE → ISSUE when start=1.
- ISSUE:
  - rd_en=1 for exactly NUM_TILES consecutive cycles; tile_addr=0..NUM_TILES-1 in order.
  - After the last tile is issued → WAIT.
- WAIT: rd_en=0; holds until the last tile's result is accumulated → OUTPUT.
- OUTPUT:
  - out_valid=1; out_j/out_k are held stable until out_valid & out_ready.
  - On handshake: if pair_addr < NUM_PAIRS-1, pair_addr increments and the FSM → ISSUE; otherwise → IDLE with a done pulse.
- Tracking: a valid shift register of depth 1+CHAIN_LATENCY carries, per issued tile, a valid bit plus a first-tile flag.
- Accumulation, on each cycle the shift-register output is valid:
  - acc_j = (first ? 0 : acc_j) + sext(chain_j); acc_k likewise.
  - Default arithmetic is two's-complement wrap at ACC_WIDTH.
- pair_addr is constant for a whole pair. tile_addr returns to 0 outside ISSUE.
- start while busy is ignored. start in the same cycle as done is ignored. Pairs never overlap in the chain.
- Reset, in any state: FSM → IDLE and the shift register is cleared. busy, done, rd_en, out_valid, tile_addr, pair_addr, out_j and out_k are all 0 from the next cycle. Results in flight are discarded.

## Timing
- start high in IDLE at cycle 0 → busy=1 and rd_en=1 from cycle 1.
- Tile t is issued at cycle 1+t, its data reaches the chain at 2+t, and its result is sampled at 2+t+CHAIN_LATENCY.
- out_valid first rises at cycle NUM_TILES+CHAIN_LATENCY+2 (17 with defaults).
- Handshake at cycle h → next pair's rd_en at h+1, and out_valid=0 at h+1.
- Final handshake at h → done=1 and busy=0 at h+1.
- Pair throughput with out_ready held high: NUM_TILES+CHAIN_LATENCY+2 cycles per pair.

## Configuration
- CHAIN_SEQ_SAT_EN defined: every accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Saturation is applied per add, and saturated values stay clamped through later adds.
- Not defined: plain wrap-around addition.

## Test plan
- Defaults, chain model returns chain_j=100·(t+1), chain_k=-(t+1) for tile t → out_j=1000, out_k=-10, out_valid rises at cycle 17, tile_addr 0,1,2,3 at cycles 1–4.
- out_ready held low 5 cycles during OUTPUT → out_valid stays 1, out_j/out_k unchanged, rd_en stays 0. The next pair's rd_en rises the cycle after out_ready goes high.
- Full layer, 8 pairs, out_ready=1 → pair_addr steps 0..7, 8 handshakes, one done pulse, busy falls with done.
- Four partials of 2^22 with ACC_WIDTH=24:
  - without CHAIN_SEQ_SAT_EN → out_j=0;
  - with CHAIN_SEQ_SAT_EN → out_j=8388607;
  - four partials of -2^22 with CHAIN_SEQ_SAT_EN → out_j=-8388608.
- reset asserted during ISSUE (tile 2) → all outputs 0 next cycle. A new start then gives a correct result for pair 0 (1000/-10) with no residue from the aborted pair.
- start pulsed during WAIT and OUTPUT → no effect. Addresses and results are identical to a run without the extra pulses.
